// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU-side bundle between two requesters, the shared ALU and the arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' and ALU's view.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctrl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctrl;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero, busy,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero, busy,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters with a registered operand/result path.
// Latency: accept at edge N, response valid from cycle N+2. Initiation interval is 3 cycles or more.
// Backpressure: RESP holds result/zero until the owner's rsp_ready is seen. Requests stall (ready=0) meanwhile.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]       ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             last_grant;
    logic             gnt_vld;
    logic             gnt_port;
    op_t              req0_op;
    op_t              req1_op;
    op_t              gnt_op;
    logic             accept;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_ctrl_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q;

    logic             req0_rdy;
    logic             req1_rdy;
    logic             rsp0_vld;
    logic             rsp1_vld;
    logic             rsp_ack;

    assign req0_op = '{ctrl: bus.req0_ctrl, a: bus.req0_a, b: bus.req0_b};
    assign req1_op = '{ctrl: bus.req1_ctrl, a: bus.req1_a, b: bus.req1_b};

    // Under contention the port that did not win last time is served.
    always_comb begin
        gnt_vld  = bus.req0_valid | bus.req1_valid;
        gnt_port = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_port = ~last_grant;
        end else if (bus.req1_valid) begin
            gnt_port = 1'b1;
        end
        gnt_op = gnt_port ? req1_op : req0_op;
    end

    always_comb begin
        state_nxt = state;
        req0_rdy  = 1'b0;
        req1_rdy  = 1'b0;
        rsp0_vld  = 1'b0;
        rsp1_vld  = 1'b0;
        rsp_ack   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    req0_rdy  = ~gnt_port;
                    req1_rdy  = gnt_port;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                // Only the owner's ready can retire the response.
                rsp0_vld = ~owner;
                rsp1_vld = owner;
                rsp_ack  = owner ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= 4'b0000;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a_q    <= gnt_op.a;
                alu_b_q    <= gnt_op.b;
                alu_ctrl_q <= gnt_op.ctrl;
                owner      <= gnt_port;
                last_grant <= gnt_port;
            end
            // The ALU has had the whole EXEC cycle to settle on the registered operands.
            if (state == EXEC) begin
                rsp_data_q <= bus.alu_result;
                rsp_zero_q <= bus.alu_zero;
            end
        end
    end

    assign bus.req0_ready = req0_rdy;
    assign bus.req1_ready = req1_rdy;
    assign bus.rsp0_valid = rsp0_vld;
    assign bus.rsp1_valid = rsp1_vld;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU instance between two requesters, e.g. the integer pipeline (port 0) and an address/branch helper unit (port 1). The block grants requests round-robin, registers the granted operands and control onto the ALU inputs, and captures the ALU result and zero flag. It then returns the result to the granted requester over a valid/ready response handshake.

Parameters:
WIDTH, 32, operand/result width; must match the shared ALU's WIDTH

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle (when valid is also high)
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_ctrl  input  4  requester 0 ALU control code
req1_valid  input  1  requester 1 has an operation pending
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_ctrl  input  4  requester 1 ALU control code
alu_a  output  WIDTH  registered operand a to shared ALU
alu_b  output  WIDTH  registered operand b to shared ALU
alu_ctrl  output  4  registered control code to shared ALU
alu_result  input  WIDTH  shared ALU output
alu_zero  input  1  shared ALU zero flag
rsp0_valid  output  1  result available for requester 0
rsp0_ready  input  1  requester 0 consumes result
rsp1_valid  output  1  result available for requester 1
rsp1_ready  input  1  requester 1 consumes result
rsp_data  output  WIDTH  captured result (shared by both response ports)
rsp_zero  output  1  captured zero flag
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state = IDLE; all ready/valid outputs 0; busy 0.
  - alu_a, alu_b, rsp_data = 0; alu_ctrl = 4'b0000; rsp_zero = 0.
  - owner = 0; last_grant = 1, so port 0 wins the first contention.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE grant (combinational):
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - reqN_ready = (state == IDLE) && granted N. At most one ready is high in any cycle.
- IDLE accept (on the edge where valid & ready):
  - Latch a/b/ctrl into alu_a/alu_b/alu_ctrl.
  - owner <= N; last_grant <= N; go to EXEC.
  - No valid: remain in IDLE; the ALU registers hold their last values.
- EXEC (exactly 1 cycle): the ALU settles. On the edge, rsp_data <= alu_result and rsp_zero <= alu_zero; go to RESP.
- RESP:
  - rsp{owner}_valid = 1; the other rsp valid = 0.
  - rsp_data and rsp_zero are held stable until the handshake completes.
  - On rsp{owner}_ready = 1, go to IDLE next cycle. Otherwise stay in RESP indefinitely (backpressure).
  - reqN_ready = 0 throughout. New requests wait; they are not dropped.
- Latency: accept at edge N; result visible with rsp valid from cycle N+2. Minimum initiation interval is 3 cycles per operation.
- Requester rule: reqN_valid and its operands stay stable until ready. The block does not check this.
- Control codes pass through unmodified. Undefined codes yield whatever the ALU produces (0 for the current ALU).
- Fairness: under continuous valid on both ports, grants alternate strictly 0,1,0,1,...
- Simultaneous events:
  - rsp_ready asserted in the same cycle RESP is entered completes that cycle.
  - The non-owner's rsp_ready is ignored.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is issued. All registers return to their reset values on the next edge.

Test Plan:
- Single op, port 0: req0 a=5, b=3, ctrl=4'b0000. Required: req0_ready high in cycle 0; rsp0_valid high from cycle 2 with rsp_data=8 and rsp_zero=0; rsp1_valid stays 0.
- Contention after reset: both valid in the same cycle; req0 is SUB 7-7, req1 is SLT with a=32'hFFFFFFFF, b=1. Required:
  - Port 0 is granted first and returns 0 with rsp_zero=1.
  - Port 1 is accepted in the cycle after the response completes and returns 1.
- Round-robin: hold both valid for 6 operations. Required grant order 0,1,0,1,0,1, with each response on the matching rspN_valid.
- Backpressure: accept req1 SRA with a=32'h80000000, b=4; hold rsp1_ready=0 for 5 cycles. Required:
  - rsp1_valid stays high and rsp_data holds 32'hF8000000 throughout.
  - A pending req0 sees req0_ready=0 until rsp1_ready rises.
- Reset in EXEC: accept an op, then assert reset in the next cycle. Required: no rsp valid ever pulses for that op, and all outputs are at reset values after the edge.
- Wrong-port ready: while in RESP for owner 0, assert rsp1_ready only. Required: the block stays in RESP until rsp0_ready is asserted.
